bt_status_tx: RTL and testbench

- UART transmitter that reports player state (track index, volume) back to the phone over the Bluetooth module's RX pin.
- Other direction of the Bluetooth command link: the receive path turns phone bytes into CURRENT and vol; this block sends CURRENT and vol back so the app display stays in sync.
- Sits beside the Bluetooth command block in the top level. Inputs are its CURRENT/vol outputs; output drives the board TXD pin.

---
 rtl/bt_pkg.sv | 55 +++++
 rtl/uart_tx_byte.sv | 108 ++++++++++
 rtl/bt_status_tx.sv | 119 +++++++++++
 tb/tb_bt_status_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt_pkg
// Description : Shared definitions for the Bluetooth command link (receive
//               command bytes, transmit status frame, UART state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package bt_pkg;

  // Status frame layout: header byte, volume level byte, XOR checksum byte
  localparam logic [4:0] FRAME_HDR   = 5'b11000;
  localparam int         FRAME_BYTES = 3;

  // Command bytes understood by the receive side, kept here so both
  // directions of the link agree on a single definition
  localparam logic [7:0] CMD_A1 = 8'hA1;
  localparam logic [7:0] CMD_A2 = 8'hA2;
  localparam logic [7:0] CMD_A3 = 8'hA3;
  localparam logic [7:0] CMD_A4 = 8'hA4;
  localparam logic [7:0] CMD_B1 = 8'hB1;
  localparam logic [7:0] CMD_B2 = 8'hB2;
  localparam logic [7:0] CMD_B3 = 8'hB3;
  localparam logic [7:0] CMD_B4 = 8'hB4;

  // Serializer line states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Frame sequencer states
  typedef enum logic {
    TOP_IDLE = 1'b0,
    TOP_SEND = 1'b1
  } top_state_t;

  // Byte idx of a status frame built from a track index and volume level
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [2:0] cur,
                                            input logic [7:0] lvl);
    logic [7:0] hdr;
    logic [7:0] res;
    hdr = {FRAME_HDR, cur};
    case (idx)
      2'd0:    res = hdr;
      2'd1:    res = lvl;
      default: res = hdr ^ lvl;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 LSB-first serializer. A start request in the last stop-bit
//               cycle chains the next byte with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import bt_pkg::*;
#(
  parameter int BAUD_DIV = 10417
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TXD,
  output logic       done
);

  localparam int               CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  uart_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             txd_next;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // Next-state, next line level and end-of-byte pulse
  always_comb begin
    state_next = state;
    cnt_next   = bit_end ? '0 : cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    txd_next   = TXD;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        txd_next = 1'b1;
        if (start) begin
          state_next = ST_START;
          shift_next = data;
          txd_next   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          bit_next   = 3'd0;
          txd_next   = shift[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next = bit_idx + 3'd1;
            txd_next = shift[bit_idx + 3'd1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done = 1'b1;
          if (start) begin
            state_next = ST_START;
            shift_next = data;
            txd_next   = 1'b0;
          end else begin
            state_next = ST_IDLE;
            txd_next   = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        txd_next   = 1'b1;
      end
    endcase
  end

  // Line state register; TXD is registered so the pin never glitches
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      TXD     <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      TXD     <= txd_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bt_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : bt_status_tx
// Description : Sends {header|track, volume level, checksum} status frames to
//               the phone whenever the track or volume level changes, on
//               request, and once after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_status_tx
  import bt_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] vol,
  input  logic [2:0]  CURRENT,
  input  logic        req,
  output logic        TXD,
  output logic        busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  top_state_t state, state_next;
  logic       pend;
  logic [2:0] last_cur;
  logic [7:0] last_lvl;
  logic [2:0] cur_snap;
  logic [7:0] lvl_snap;
  logic [1:0] byte_idx;
  logic       trig;
  logic       last_byte;
  logic       ser_start;
  logic [7:0] ser_data;
  logic       ser_done;
  logic       unused_vol_lo;

  // The low volume byte is deliberately not reported
  assign unused_vol_lo = ^vol[7:0];
  assign last_byte     = (byte_idx == 2'(FRAME_BYTES - 1));
  assign busy          = (state == TOP_SEND);

  // Trigger detection and byte sequencing into the serializer
  always_comb begin
    state_next = state;
    trig       = 1'b0;
    ser_start  = 1'b0;
    ser_data   = 8'h00;
    case (state)
      TOP_IDLE: begin
        if (pend || (CURRENT != last_cur) || (vol[15:8] != last_lvl)) begin
          trig       = 1'b1;
          ser_start  = 1'b1;
          ser_data   = frame_byte(2'd0, CURRENT, vol[15:8]);
          state_next = TOP_SEND;
        end
      end
      TOP_SEND: begin
        if (ser_done) begin
          if (last_byte) begin
            state_next = TOP_IDLE;
          end else begin
            ser_start = 1'b1;
            ser_data  = frame_byte(byte_idx + 2'd1, cur_snap, lvl_snap);
          end
        end
      end
      default: state_next = TOP_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= TOP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Snapshot, last-reported values, byte index and pending-request flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend     <= 1'b1;   // boot announcement after reset
      last_cur <= 3'd0;
      last_lvl <= 8'h00;
      cur_snap <= 3'd0;
      lvl_snap <= 8'h00;
      byte_idx <= 2'd0;
    end else begin
      if (trig) begin
        cur_snap <= CURRENT;
        lvl_snap <= vol[15:8];
        last_cur <= CURRENT;
        last_lvl <= vol[15:8];
        byte_idx <= 2'd0;
      end else if (busy && ser_done && !last_byte) begin
        byte_idx <= byte_idx + 2'd1;
      end
      // A request coinciding with a frame start survives the clear
      pend <= req | (pend & ~trig);
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .CLK   (CLK),
    .RST   (RST),
    .start (ser_start),
    .data  (ser_data),
    .TXD   (TXD),
    .done  (ser_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_bt_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_status_tx
// Description : Self-checking bench for bt_status_tx (BAUD_DIV = 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_status_tx;

  localparam int DIV   = 10;
  localparam int FRAME = 30 * DIV;

  logic        CLK;
  logic        RST;
  logic [15:0] vol;
  logic [2:0]  CURRENT;
  logic        req;
  logic        TXD;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  bt_status_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .vol     (vol),
    .CURRENT (CURRENT),
    .req     (req),
    .TXD     (TXD),
    .busy    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model: line level per cycle ----------------
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  bit         m_pend   = 1'b1;
  logic [2:0] m_last_cur = 3'd0;
  logic [7:0] m_last_lvl = 8'h00;
  logic       m_bits [30];

  task automatic build_frame(input logic [2:0] cur, input logic [7:0] lvl);
    logic [7:0] b [3];
    b[0] = {5'b11000, cur};
    b[1] = lvl;
    b[2] = b[0] ^ b[1];
    for (int k = 0; k < 3; k++) begin
      m_bits[10*k] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[10*k+1+i] = b[k][i];
      m_bits[10*k+9] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (chk_en) begin
        check("txd",  {31'd0, TXD},  {31'd0, (m_active ? m_bits[m_pos / DIV] : 1'b1)});
        check("busy", {31'd0, busy}, {31'd0, m_active});
      end
      if (RST) begin
        m_active   = 1'b0;
        m_pend     = 1'b1;
        m_last_cur = 3'd0;
        m_last_lvl = 8'h00;
      end else begin
        if (m_active) begin
          m_pos++;
          if (m_pos == FRAME) m_active = 1'b0;
        end else if (m_pend || CURRENT != m_last_cur || vol[15:8] != m_last_lvl) begin
          build_frame(CURRENT, vol[15:8]);
          m_active   = 1'b1;
          m_pos      = 0;
          m_pend     = 1'b0;
          m_last_cur = CURRENT;
          m_last_lvl = vol[15:8];
        end
        if (req) m_pend = 1'b1;
      end
    end
  end

  // ---------------- UART monitor (mid-bit sampling) ----------------
  logic [7:0] rx_bytes [$];
  bit         mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_byte = 8'h00;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (TXD === 1'b0) begin
          mon_busy = 1'b1;
          mon_cnt  = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
          mon_byte[(mon_cnt - 15) / 10] = TXD;
        if (mon_cnt == 95) begin
          check("stop_bit", {31'd0, TXD}, 32'd1);
          rx_bytes.push_back(mon_byte);
          mon_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]  cur;
    logic [15:0] v;
    logic        rq;
    int          wait_c;
    int          nbytes;
    logic [7:0]  e0, e1, e2;
  } rec_t;

  rec_t tbl [8];
  int   mark;

  task automatic check_bytes(input string name, input int n, input logic [7:0] exp [6]);
    check({name, "_count"}, rx_bytes.size() - mark, n);
    if (rx_bytes.size() - mark == n)
      for (int i = 0; i < n; i++) check({name, "_byte"}, rx_bytes[mark+i], exp[i]);
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (!busy && k < 50) begin
      tick(1);
      k++;
    end
    check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    logic [7:0] ex [6];
    int r;

    tbl[0] = '{3'd2, 16'h0000, 1'b0, 320,  3, 8'hC2, 8'h00, 8'hC2};
    tbl[1] = '{3'd2, 16'h0000, 1'b0, 1000, 0, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{3'd0, 16'h2020, 1'b0, 320,  3, 8'hC0, 8'h20, 8'hE0};
    tbl[3] = '{3'd0, 16'h20FF, 1'b0, 400,  0, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{3'd0, 16'h20FF, 1'b1, 320,  3, 8'hC0, 8'h20, 8'hE0};
    tbl[5] = '{3'd1, 16'h5000, 1'b0, 320,  3, 8'hC1, 8'h50, 8'h91};
    tbl[6] = '{3'd7, 16'hF0AB, 1'b0, 320,  3, 8'hC7, 8'hF0, 8'h37};
    tbl[7] = '{3'd3, 16'hF0AB, 1'b0, 320,  3, 8'hC3, 8'hF0, 8'h33};

    RST = 1'b1; vol = 16'h0000; CURRENT = 3'd0; req = 1'b0;
    tick(2);
    chk_en = 1'b1;
    tick(2);
    check("reset_txd",  {31'd0, TXD},  32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Boot announcement
    mark = rx_bytes.size();
    RST  = 1'b0;
    tick(320);
    ex = '{8'hC0, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00};
    check_bytes("boot", 3, ex);

    for (int t = 0; t < 8; t++) begin
      mark    = rx_bytes.size();
      CURRENT = tbl[t].cur;
      vol     = tbl[t].v;
      req     = tbl[t].rq;
      tick(1);
      req = 1'b0;
      tick(tbl[t].wait_c - 1);
      ex = '{tbl[t].e0, tbl[t].e1, tbl[t].e2, 8'h00, 8'h00, 8'h00};
      check_bytes($sformatf("vec%0d", t), tbl[t].nbytes, ex);
    end

    // Change plus request in the middle of a frame: one follow-up frame
    mark    = rx_bytes.size();
    CURRENT = 3'd1;
    tick(1);
    wait_busy("midframe");
    tick(149);
    CURRENT = 3'd3;
    req     = 1'b1;
    tick(1);
    req = 1'b0;
    tick(700);
    ex = '{8'hC1, 8'hF0, 8'h31, 8'hC3, 8'hF0, 8'h33};
    check_bytes("midframe", 6, ex);

    // Request in the same cycle as a change-triggered start: two frames
    mark    = rx_bytes.size();
    CURRENT = 3'd2;
    req     = 1'b1;
    tick(1);
    req = 1'b0;
    tick(700);
    ex = '{8'hC2, 8'hF0, 8'h32, 8'hC2, 8'hF0, 8'h32};
    check_bytes("req_same", 6, ex);

    // Reset in the middle of a frame, then a fresh boot frame
    CURRENT = 3'd0;
    tick(1);
    wait_busy("rst_mid");
    tick(119);
    RST = 1'b1;
    tick(1);
    check("rst_mid_txd",  {31'd0, TXD},  32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    CURRENT = 3'd5;
    vol     = 16'h3300;
    tick(2);
    mark = rx_bytes.size();
    RST  = 1'b0;
    tick(330);
    ex = '{8'hC5, 8'h33, 8'hF6, 8'h00, 8'h00, 8'h00};
    check_bytes("rst_boot", 3, ex);

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 12000; n++) begin
      r   = $urandom_range(0, 999);
      req = 1'b0;
      RST = (r == 999);
      if (r < 4)        CURRENT = 3'($urandom_range(0, 7));
      else if (r < 8)   vol = 16'($urandom);
      else if (r < 12)  vol[7:0] = 8'($urandom);
      else if (r < 15)  req = 1'b1;
      tick(1);
    end
    RST = 1'b0;
    req = 1'b0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
